// File: rtl/cu_multicycle_param.sv
// Multi-cycle control unit with NUM_REGS x DATA_WIDTH register file.
// Ports: clk, rst (async high); instr_valid/instr/instr_ready handshake;
//   result (write-back data); operand1/2, offset, opcode, sel1, sel3, w_r
//   to the ALU/memory datapath; busy, retired status; dbg_addr/dbg_data.
module cu_multicycle_param #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter bit ZERO_REG   = 1'b0,
    localparam int REG_BITS    = $clog2(NUM_REGS),
    localparam int INSTR_WIDTH = 2 + 3*REG_BITS + DATA_WIDTH + 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_ready,
    input  logic [DATA_WIDTH-1:0]  result,
    output logic [DATA_WIDTH-1:0]  operand1,
    output logic [DATA_WIDTH-1:0]  operand2,
    output logic [DATA_WIDTH-1:0]  offset,
    output logic [3:0]             opcode,
    output logic                   sel1,
    output logic                   sel3,
    output logic                   w_r,
    output logic                   busy,
    output logic                   retired,
    input  logic [REG_BITS-1:0]    dbg_addr,
    output logic [DATA_WIDTH-1:0]  dbg_data
);

    localparam logic [1:0] C_NOP = 2'b00;
    localparam logic [1:0] C_STD = 2'b01;
    localparam logic [1:0] C_LD  = 2'b10;
    localparam logic [1:0] C_ST  = 2'b11;

    localparam int P_OFF = 4;
    localparam int P_RS2 = P_OFF + DATA_WIDTH;
    localparam int P_RS1 = P_RS2 + REG_BITS;
    localparam int P_RD  = P_RS1 + REG_BITS;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DEC  = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t state, nxt;

    logic [DATA_WIDTH-1:0] rf [NUM_REGS];

    logic [1:0]            in_cls;
    logic [REG_BITS-1:0]   in_rd, in_rs1, in_rs2;
    logic [DATA_WIDTH-1:0] in_off;
    logic [3:0]            in_opc;

    // Only class and rd are needed after accept; the rest lands
    // directly in the operand/offset/opcode registers.
    logic [1:0]            ir_cls;
    logic [REG_BITS-1:0]   ir_rd;

    logic accept, retire_nxt, wr_en;

    assign in_cls = instr[INSTR_WIDTH-1 -: 2];
    assign in_rd  = instr[P_RD  +: REG_BITS];
    assign in_rs1 = instr[P_RS1 +: REG_BITS];
    assign in_rs2 = instr[P_RS2 +: REG_BITS];
    assign in_off = instr[P_OFF +: DATA_WIDTH];
    assign in_opc = instr[3:0];

    assign instr_ready = (state == S_IDLE);
    assign busy        = ~instr_ready;
    assign accept      = instr_ready & instr_valid;

    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE:  nxt = instr_valid ? S_DEC : S_IDLE;
            S_DEC:   nxt = (ir_cls == C_NOP) ? S_IDLE : S_EXE;
            S_EXE:   nxt = (ir_cls == C_STD) ? S_WB : S_MEM;
            S_MEM:   nxt = (ir_cls == C_LD) ? S_WB : S_IDLE;
            S_WB:    nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Only legal completion states retire; an illegal encoding
    // falling back to IDLE does not.
    assign retire_nxt = (nxt == S_IDLE) &&
                        (state == S_DEC || state == S_MEM ||
                         state == S_WB);

    assign wr_en = (state == S_WB) &&
                   !(ZERO_REG && (ir_rd == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_cls   <= C_NOP;
            ir_rd    <= '0;
            operand1 <= '0;
            operand2 <= '0;
            offset   <= '0;
            opcode   <= 4'hF;
            sel1     <= 1'b0;
            sel3     <= 1'b0;
            w_r      <= 1'b0;
            retired  <= 1'b0;
        end else begin
            if (accept) begin
                ir_cls   <= in_cls;
                ir_rd    <= in_rd;
                operand1 <= rf[in_rs1];
                operand2 <= in_cls[1] ? rf[in_rd] : rf[in_rs2];
                offset   <= in_off;
                opcode   <= in_opc;
                sel1     <= (in_cls == C_STD) || (in_cls == C_ST);
                sel3     <= in_cls[1];
            end
            w_r     <= (nxt == S_MEM) && (ir_cls == C_ST);
            retired <= retire_nxt;
        end
    end

    // Register 0 resets to 0 and is never written when ZERO_REG=1,
    // so reads of it need no extra masking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                rf[i] <= DATA_WIDTH'(i);
        end else if (wr_en) begin
            rf[ir_rd] <= result;
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_cu_multicycle_param.sv
// Testbench for cu_multicycle_param: directed and random instructions
// on a ZERO_REG=0 and a ZERO_REG=1 instance against a register model.
module tb_cu_multicycle_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [19:0] instr;
    logic [7:0]  result;
    logic [1:0]  dbg_addr;

    logic       rdy_a, s1_a, s3_a, wr_a, busy_a, ret_a;
    logic [7:0] op1_a, op2_a, off_a, dbg_a;
    logic [3:0] opc_a;
    logic       rdy_z, s1_z, s3_z, wr_z, busy_z, ret_z;
    logic [7:0] op1_z, op2_z, off_z, dbg_z;
    logic [3:0] opc_z;

    int n_chk = 0;
    int n_fail = 0;
    int ma[4];
    int mz[4];

    always #10 clk = ~clk;

    cu_multicycle_param #(.ZERO_REG(1'b0)) dut_a (
        .clk(clk), .rst(rst), .instr_valid(instr_valid),
        .instr(instr), .instr_ready(rdy_a), .result(result),
        .operand1(op1_a), .operand2(op2_a), .offset(off_a),
        .opcode(opc_a), .sel1(s1_a), .sel3(s3_a), .w_r(wr_a),
        .busy(busy_a), .retired(ret_a), .dbg_addr(dbg_addr),
        .dbg_data(dbg_a)
    );

    cu_multicycle_param #(.ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst(rst), .instr_valid(instr_valid),
        .instr(instr), .instr_ready(rdy_z), .result(result),
        .operand1(op1_z), .operand2(op2_z), .offset(off_z),
        .opcode(opc_z), .sel1(s1_z), .sel3(s3_z), .w_r(wr_z),
        .busy(busy_z), .retired(ret_z), .dbg_addr(dbg_addr),
        .dbg_data(dbg_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mk(input int c, input int rd,
        input int rs1, input int rs2, input int off, input int opc);
        return {c[1:0], rd[1:0], rs1[1:0], rs2[1:0], off[7:0], opc[3:0]};
    endfunction

    task automatic mreset();
        for (int i = 0; i < 4; i++) begin
            ma[i] = i;
            mz[i] = i;
        end
    endtask

    // Architectural effect of a completed instruction.
    task automatic mwrite(input int c, input int rd, input int res);
        if (c == 1 || c == 2) begin
            ma[rd] = res;
            if (rd != 0) mz[rd] = res;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dbgchk();
        for (int i = 0; i < 4; i++) begin
            dbg_addr = i[1:0];
            #1;
            chk($sformatf("dbg_a[%0d]", i), dbg_a, ma[i]);
            chk($sformatf("dbg_z[%0d]", i), dbg_z, mz[i]);
        end
    endtask

    task automatic chkdef();
        chk("def_opc_a", opc_a, 4'hF);
        chk("def_opc_z", opc_z, 4'hF);
        chk("def_op1", {op1_a, op1_z}, 0);
        chk("def_op2", {op2_a, op2_z}, 0);
        chk("def_off", {off_a, off_z}, 0);
        chk("def_sel", {s1_a, s3_a, s1_z, s3_z}, 0);
        chk("def_wr_ret", {wr_a, wr_z, ret_a, ret_z}, 0);
        chk("def_busy", {busy_a, busy_z}, 0);
        chk("def_rdy", {rdy_a, rdy_z}, 2'b11);
    endtask

    task automatic issue(input int c, input int rd, input int rs1,
        input int rs2, input int off, input int opc, input int res);
        int lat;
        int e1a, e1z, e2a, e2z;
        lat = (c == 0) ? 2 : (c == 2) ? 5 : 4;
        e1a = ma[rs1];
        e1z = mz[rs1];
        e2a = (c >= 2) ? ma[rd] : ma[rs2];
        e2z = (c >= 2) ? mz[rd] : mz[rs2];
        @(negedge clk);
        instr = mk(c, rd, rs1, rs2, off, opc);
        instr_valid = 1'b1;
        result = res[7:0];
        step();
        instr_valid = 1'b0;
        instr = 20'($urandom);
        chk("acc_busy", {busy_a, busy_z, rdy_a}, 3'b110);
        chk("acc_op1_a", op1_a, e1a);
        chk("acc_op1_z", op1_z, e1z);
        if (c != 0) begin
            chk("acc_op2_a", op2_a, e2a);
            chk("acc_op2_z", op2_z, e2z);
        end
        chk("acc_off", off_a, off & 8'hFF);
        chk("acc_opc", opc_a, opc & 4'hF);
        chk("acc_sel1", s1_a, (c == 1 || c == 3));
        chk("acc_sel3", s3_a, (c >= 2));
        chk("acc_wr", {wr_a, wr_z, ret_a}, 0);
        for (int k = 2; k <= lat + 1; k++) begin
            step();
            chk($sformatf("ret_a e%0d", k), ret_a, k == lat);
            chk($sformatf("ret_z e%0d", k), ret_z, k == lat);
            chk($sformatf("wr e%0d", k), wr_a, (c == 3 && k == 3));
            chk($sformatf("busy e%0d", k), busy_a, k < lat);
            chk($sformatf("hold e%0d", k), {opc_a, off_a},
                {opc[3:0], off[7:0]});
        end
        mwrite(c, rd, res);
        dbgchk();
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        result = '0;
        dbg_addr = '0;
        mreset();
        #25;
        chkdef();
        @(negedge clk);
        rst = 1'b0;
        step();
        chkdef();
        dbgchk();

        // std, load, store, nop
        issue(1, 0, 2, 3, 8'h00, 2, 8'h05);
        issue(2, 1, 3, 0, 8'h04, 6, 8'hAA);
        issue(3, 2, 1, 0, 8'h10, 7, 8'h99);
        issue(0, 3, 1, 2, 8'h33, 1, 8'h44);

        // back-to-back with instr_valid held high
        @(negedge clk);
        instr = mk(1, 3, 0, 0, 0, 2);
        instr_valid = 1'b1;
        result = 8'h07;
        step();
        chk("b2b_accA", opc_a, 4'h2);
        @(negedge clk);
        instr = mk(1, 0, 3, 1, 0, 5);
        for (int k = 2; k <= 4; k++) begin
            step();
            chk($sformatf("b2b_holdA e%0d", k), opc_a, 4'h2);
            chk($sformatf("b2b_retA e%0d", k), ret_a, k == 4);
        end
        mwrite(1, 3, 7);
        result = 8'h3C;
        step();
        chk("b2b_accB", opc_a, 4'h5);
        chk("b2b_ret_low", ret_a, 1'b0);
        chk("b2b_op1_a", op1_a, ma[3]);
        chk("b2b_op1_z", op1_z, mz[3]);
        chk("b2b_op2_a", op2_a, ma[1]);
        @(negedge clk);
        instr = mk(1, 2, 0, 0, 0, 9);
        for (int k = 6; k <= 8; k++) begin
            step();
            chk($sformatf("b2b_holdB e%0d", k), opc_a, 4'h5);
            chk($sformatf("b2b_retB e%0d", k), ret_z, k == 8);
        end
        mwrite(1, 0, 8'h3C);
        result = 8'h81;
        step();
        instr_valid = 1'b0;
        chk("b2b_accC", opc_a, 4'h9);
        chk("b2b_op1C_a", op1_a, ma[0]);
        chk("b2b_op1C_z", op1_z, mz[0]);
        for (int k = 10; k <= 13; k++) begin
            step();
            chk($sformatf("b2b_retC e%0d", k), ret_a, k == 12);
        end
        mwrite(1, 2, 8'h81);
        dbgchk();

        // random instructions
        for (int n = 0; n < 40; n++) begin
            issue($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 255), $urandom_range(0, 15),
                  $urandom_range(0, 255));
        end

        // reset in the middle of EXECUTE
        @(negedge clk);
        instr = mk(1, 1, 2, 3, 0, 4);
        instr_valid = 1'b1;
        result = 8'h77;
        step();
        instr_valid = 1'b0;
        step();
        #3;
        rst = 1'b1;
        #1;
        chkdef();
        @(negedge clk);
        rst = 1'b0;
        mreset();
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rst_noret e%0d", k), {ret_a, ret_z}, 0);
            chk($sformatf("rst_idle e%0d", k), {busy_a, busy_z}, 0);
        end
        dbgchk();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
